// File: rtl/control_pkg.sv
// Shared encodings for the instruction decoder: opcodes, ALU operations,
// write-back sources and the bundle of control outputs.
package control_pkg;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_I    = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BR0  = 3'd4;
  localparam logic [2:0] OP_BR1  = 3'd5;
  localparam logic [2:0] OP_JIN  = 3'd6;
  localparam logic [2:0] OP_JOUT = 3'd7;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_SL   = 3'd5;
  localparam logic [2:0] ALU_SR   = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  localparam logic [2:0] RS_MEM  = 3'd0;
  localparam logic [2:0] RS_ALU  = 3'd1;
  localparam logic [2:0] RS_LINK = 3'd2;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [2:0] reg_store;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump_out;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/func decode into the control bundle.
// Anything not set explicitly for an opcode stays 0.
module control_decode
  import control_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [3:0] func,
  output ctrl_t      ctrl
);

  // Full decode over all opcodes; defaults keep every field defined.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_store = RS_ALU;
        case (func[1:0])
          2'd0:    ctrl.alu_op = ALU_ADD;
          2'd1:    ctrl.alu_op = ALU_SUB;
          2'd2:    ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_store = RS_ALU;
        case (func[3:2])
          2'd0:    ctrl.alu_op = ALU_ADD;
          2'd1:    ctrl.alu_op = ALU_SL;
          2'd2:    ctrl.alu_op = ALU_SR;
          default: ctrl.alu_op = ALU_XOR;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_store = RS_MEM;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BR0, OP_BR1: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_JIN: begin
        ctrl.branch    = 1'b1;
        ctrl.reg_store = RS_LINK;
      end
      default: begin
        // OP_JOUT: jump-out always travels with a branch redirect.
        ctrl.branch   = 1'b1;
        ctrl.jump_out = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder top: combinational decode followed by an
// async-reset output register, giving exactly one cycle of latency.
module control_unit
  import control_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [3:0] func,
  output logic       RegWrite,
  output logic       ALUsrc,
  output logic [2:0] ALUop,
  output logic [2:0] RegStore,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       Branch,
  output logic       JumpOut
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode (opcode),
    .func   (func),
    .ctrl   (ctrl_d)
  );

  // Register the decode; reset clears immediately and drops any in-flight decode.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign RegWrite = ctrl_q.reg_write;
  assign ALUsrc   = ctrl_q.alu_src;
  assign ALUop    = ctrl_q.alu_op;
  assign RegStore = ctrl_q.reg_store;
  assign MemWrite = ctrl_q.mem_write;
  assign MemRead  = ctrl_q.mem_read;
  assign Branch   = ctrl_q.branch;
  assign JumpOut  = ctrl_q.jump_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Outputs are compared as one packed
// vector {RegWrite, ALUsrc, ALUop, RegStore, MemWrite, MemRead, Branch, JumpOut}.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [3:0] func = 4'd0;
  logic       RegWrite, ALUsrc, MemWrite, MemRead, Branch, JumpOut;
  logic [2:0] ALUop, RegStore;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .CLK      (CLK),
    .reset    (reset),
    .opcode   (opcode),
    .func     (func),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .ALUop    (ALUop),
    .RegStore (RegStore),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Branch   (Branch),
    .JumpOut  (JumpOut)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] pk(input logic rw, input logic src,
                                     input logic [2:0] op, input logic [2:0] rs,
                                     input logic mw, input logic mr,
                                     input logic br, input logic jo);
    return {rw, src, op, rs, mw, mr, br, jo};
  endfunction

  function automatic logic [11:0] obs();
    return {RegWrite, ALUsrc, ALUop, RegStore, MemWrite, MemRead, Branch, JumpOut};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [11:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 4'd0,  pk(1,1,3'd1,3'd1,0,0,0,0), "r_add"});
    vecs.push_back('{3'd0, 4'd1,  pk(1,1,3'd2,3'd1,0,0,0,0), "r_sub"});
    vecs.push_back('{3'd0, 4'd2,  pk(1,1,3'd3,3'd1,0,0,0,0), "r_or"});
    vecs.push_back('{3'd0, 4'd3,  pk(1,1,3'd4,3'd1,0,0,0,0), "r_and"});
    vecs.push_back('{3'd0, 4'd7,  pk(1,1,3'd4,3'd1,0,0,0,0), "r_func7"});
    vecs.push_back('{3'd1, 4'd0,  pk(1,0,3'd1,3'd1,0,0,0,0), "i_add"});
    vecs.push_back('{3'd1, 4'd4,  pk(1,0,3'd5,3'd1,0,0,0,0), "i_sl"});
    vecs.push_back('{3'd1, 4'd8,  pk(1,0,3'd6,3'd1,0,0,0,0), "i_sr"});
    vecs.push_back('{3'd1, 4'd12, pk(1,0,3'd7,3'd1,0,0,0,0), "i_xor"});
    vecs.push_back('{3'd1, 4'd13, pk(1,0,3'd7,3'd1,0,0,0,0), "i_func13"});
    vecs.push_back('{3'd2, 4'd5,  pk(1,0,3'd1,3'd0,0,1,0,0), "lw"});
    vecs.push_back('{3'd3, 4'd9,  pk(0,0,3'd1,3'd0,1,0,0,0), "sw"});
    vecs.push_back('{3'd4, 4'd0,  pk(0,0,3'd2,3'd0,0,0,1,0), "br0"});
    vecs.push_back('{3'd5, 4'd15, pk(0,0,3'd2,3'd0,0,0,1,0), "br1"});
    vecs.push_back('{3'd6, 4'd3,  pk(0,0,3'd0,3'd2,0,0,1,0), "jin"});
    vecs.push_back('{3'd7, 4'd6,  pk(0,0,3'd0,3'd0,0,0,1,1), "jout"});

    // reset held low while clocking
    #1;
    check("reset_initial", obs(), 12'h000);
    repeat (3) step();
    check("reset_held", obs(), 12'h000);

    @(negedge CLK);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      opcode = vecs[i].op;
      func   = vecs[i].fn;
      step();
      check(vecs[i].tag, obs(), vecs[i].exp);
    end

    // latency: input change right after an edge is not visible until the next edge
    @(negedge CLK);
    opcode = 3'd2;
    func   = 4'd0;
    step();
    check("lat_lw", obs(), pk(1,0,3'd1,3'd0,0,1,0,0));
    opcode = 3'd3;
    #3;
    check("lat_hold", obs(), pk(1,0,3'd1,3'd0,0,1,0,0));
    step();
    check("lat_sw", obs(), pk(0,0,3'd1,3'd0,1,0,0,0));

    // asynchronous reset mid-stream after a jump-out
    @(negedge CLK);
    opcode = 3'd7;
    step();
    check("pre_rst_jout", obs(), pk(0,0,3'd0,3'd0,0,0,1,1));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", obs(), 12'h000);
    step();
    check("rst_hold_clk", obs(), 12'h000);

    // release: outputs only appear after the next rising edge
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("release_no_edge", obs(), 12'h000);
    step();
    check("release_jout", obs(), pk(0,0,3'd0,3'd0,0,0,1,1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main instruction decoder of the single-issue processor. Takes the 3-bit opcode and 4-bit function field and produces datapath control signals: register write, ALU operand select, ALU operation, write-back source, memory read/write, branch and jump-out.
- Outputs are registered, so they are valid one clock after the instruction fields are applied.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all outputs immediately; reset=1 is normal operation.
- opcode  input  3  instruction class.
- func  input  4  function field; used only for opcode 0 and 1.
- RegWrite  output  1  register file write enable.
- ALUsrc  output  1  ALU B-operand select: 1 = register, 0 = immediate.
- ALUop  output  3  ALU operation: 0 none/pass, 1 add, 2 sub, 3 or, 4 and, 5 shift-left, 6 shift-right, 7 xor.
- RegStore  output  3  write-back source: 0 memory/none, 1 ALU result, 2 link (PC) value; 3-7 unused.
- MemWrite  output  1  data memory write enable.
- MemRead  output  1  data memory read enable.
- Branch  output  1  PC redirect candidate (branch or jump).
- JumpOut  output  1  selects jump-out target path.

Behaviour:
- Reset: while reset=0 (asynchronous assert), every output is 0, including ALUop=0 and RegStore=0. On release, outputs update at the next rising CLK edge.
- Latency: on each rising CLK edge with reset=1, all outputs load the decode of the current opcode/func. Latency is exactly 1 cycle. No handshake. Inputs may change every cycle.
- Every output is 0 unless listed below.
- Decode table:
  - opcode 0 (R-type): ALUsrc=1, RegStore=1, RegWrite=1. ALUop from func[1:0]: 0→1 add, 1→2 sub, 2→3 or, 3→4 and. func[3:2] is ignored.
  - opcode 1 (I-type): ALUsrc=0, RegStore=1, RegWrite=1. ALUop from func[3:2]: 0→1 add, 1→5 sl, 2→6 sr, 3→7 xor. func[1:0] is ignored.
  - opcode 2 (LW): RegWrite=1, MemRead=1, ALUop=1, RegStore=0, ALUsrc=0.
  - opcode 3 (SW): MemWrite=1, ALUop=1.
  - opcode 4 and opcode 5 (branch variants): Branch=1, ALUop=2 (subtract-compare).
  - opcode 6 (jump-in): Branch=1, RegStore=2, ALUop=0, RegWrite=0.
  - opcode 7 (jump-out): Branch=1, JumpOut=1, ALUop=0.
- The decode is complete over all 8 opcodes and all func values; no X is ever produced.
- MemRead and MemWrite are never both 1. JumpOut=1 implies Branch=1.
- Reset asserted mid-stream: outputs clear within the same delta, without waiting for a clock edge. The in-flight decode is discarded.

Decomposition:
- Package control_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BR0, OP_BR1, OP_JIN, OP_JOUT);
  - ALUop constants (ALU_NONE..ALU_XOR);
  - RegStore constants (RS_MEM=0, RS_ALU=1, RS_LINK=2);
  - a packed struct of the eight control outputs.
- One sub-module, control_decode: purely combinational opcode/func → struct. control_unit wraps it in the async-reset output register.

Test Plan:
- Reset: hold reset=0 with opcode=0, func=0 and toggle CLK → all outputs 0. Assert reset=0 mid-run after opcode 7 → all outputs 0 before the next edge.
- R-type: reset=1, opcode=0, func=0,1,2,3, one cycle each → ALUop=1,2,3,4 with ALUsrc=1, RegStore=1, RegWrite=1, others 0. func=7 → ALUop=4 (func[3:2] ignored).
- I-type: opcode=1, func=0,4,8,12 → ALUop=1,5,6,7 with ALUsrc=0, RegStore=1, RegWrite=1, others 0.
- Memory:
  - opcode=2 → RegWrite=1, MemRead=1, ALUop=1, rest 0.
  - opcode=3 → MemWrite=1, ALUop=1, rest 0.
- Branch/jump:
  - opcode=4 and opcode=5 → Branch=1, ALUop=2, rest 0.
  - opcode=6 → Branch=1, RegStore=2, rest 0.
  - opcode=7 → Branch=1, JumpOut=1, rest 0.
- Latency: change opcode from 2 to 3 just after an edge → outputs hold the LW values until the next rising edge, then switch to SW values.
